// File: rtl/lc3b_cache_if.sv
// CPU-side and physical-memory-side handshake bundle for lc3b_cache.
// The cache takes the slave view; the core/memory environment takes the master view.
interface lc3b_cache_if #(
  parameter int ADDR_W   = 16,
  parameter int S_OFFSET = 4
);
  localparam int LINE_W = 8 * (2 ** S_OFFSET);

  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_byte_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/lc3b_cache.sv
// 2-way set-associative write-back, write-allocate cache between the LC-3b core
// memory port and line-wide physical memory; hits respond in the request cycle.
module lc3b_cache #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 4,
  parameter int ADDR_W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  lc3b_cache_if.slave  bus
);
  localparam int SETS   = 2 ** S_INDEX;
  localparam int LINE_W = 8 * (2 ** S_OFFSET);
  localparam int TAG_W  = ADDR_W - S_INDEX - S_OFFSET;
  localparam logic [S_OFFSET+2:0] HI_BYTE = (S_OFFSET + 3)'(8);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e            state_q;
  logic              victim_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic [ADDR_W-1:0] pmem_addr_q;

  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   dirty_q [2];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [LINE_W-1:0] line_q  [2][SETS];

  logic [TAG_W-1:0]   req_tag;
  logic [S_INDEX-1:0] idx;
  logic [S_OFFSET+2:0] word_off;
  logic [S_OFFSET+2:0] word_off_hi;
  logic               req;
  logic               hit0;
  logic               hit1;
  logic               hit_way;
  logic               victim_way;
  logic               hit_now;
  logic [LINE_W-1:0]  sel_line;

  assign req_tag     = bus.mem_address[ADDR_W-1 -: TAG_W];
  assign idx         = bus.mem_address[S_OFFSET +: S_INDEX];
  // Bit offset of the addressed 16-bit word; address bit 0 is dropped.
  assign word_off    = {bus.mem_address[S_OFFSET-1:0], 3'b000} & ~HI_BYTE;
  assign word_off_hi = word_off | HI_BYTE;

  assign req        = bus.mem_read | bus.mem_write;
  assign hit0       = valid_q[0][idx] && (tag_q[0][idx] == req_tag);
  assign hit1       = valid_q[1][idx] && (tag_q[1][idx] == req_tag);
  assign hit_way    = !hit0;
  assign victim_way = !valid_q[0][idx] ? 1'b0 :
                      !valid_q[1][idx] ? 1'b1 : lru_q[idx];
  assign hit_now    = (state_q == IDLE) && req && (hit0 || hit1);
  assign sel_line   = line_q[hit_way][idx];

  assign bus.mem_resp     = hit_now;
  assign bus.mem_rdata    = hit_now ? sel_line[word_off +: 16] : 16'h0000;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_addr_q;
  assign bus.pmem_wdata   = pmem_write_q ? line_q[victim_q][idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      victim_q     <= 1'b0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
      valid_q[0]   <= '0;
      valid_q[1]   <= '0;
      dirty_q[0]   <= '0;
      dirty_q[1]   <= '0;
      lru_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_now) begin
            if (bus.mem_write) dirty_q[hit_way][idx] <= 1'b1;
            lru_q[idx] <= ~hit_way;
          end else if (req) begin
            victim_q <= victim_way;
            if (valid_q[victim_way][idx] && dirty_q[victim_way][idx]) begin
              state_q      <= WRITEBACK;
              pmem_write_q <= 1'b1;
              pmem_addr_q  <= {tag_q[victim_way][idx], idx, {S_OFFSET{1'b0}}};
            end else begin
              state_q     <= ALLOCATE;
              pmem_read_q <= 1'b1;
              pmem_addr_q <= {req_tag, idx, {S_OFFSET{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) begin
            state_q      <= ALLOCATE;
            pmem_write_q <= 1'b0;
            pmem_read_q  <= 1'b1;
            pmem_addr_q  <= {req_tag, idx, {S_OFFSET{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (bus.pmem_resp) begin
            state_q                  <= IDLE;
            pmem_read_q              <= 1'b0;
            pmem_addr_q              <= '0;
            valid_q[victim_q][idx]   <= 1'b1;
            dirty_q[victim_q][idx]   <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
          pmem_addr_q  <= '0;
        end
      endcase
    end
  end

  // Tag and line storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if ((state_q == ALLOCATE) && bus.pmem_resp) begin
      line_q[victim_q][idx] <= bus.pmem_rdata;
      tag_q[victim_q][idx]  <= req_tag;
    end else if (hit_now && bus.mem_write) begin
      if (bus.mem_byte_enable[0]) line_q[hit_way][idx][word_off +: 8]    <= bus.mem_wdata[7:0];
      if (bus.mem_byte_enable[1]) line_q[hit_way][idx][word_off_hi +: 8] <= bus.mem_wdata[15:8];
    end
  end
endmodule

// File: tb/tb_lc3b_cache.sv
// Directed bench for lc3b_cache: vector table of CPU accesses against a
// fixed-latency line memory, plus a reset-during-fill sequence.
module tb_lc3b_cache;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lc3b_cache_if #(.ADDR_W(16), .S_OFFSET(4)) bus ();

  lc3b_cache #(.S_INDEX(3), .S_OFFSET(4), .ADDR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [127:0] pmem [logic [15:0]];
  bit           pmem_en = 1'b1;
  bit           resp_pulse = 1'b0;
  int           wait_cnt = 0;
  int           rd_cnt = 0;
  int           wr_cnt = 0;
  int           manual_req = 0;
  int           manual_seen = 0;
  logic [15:0]  last_rd_addr = '0;
  logic [15:0]  last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;
  bit           both_seen = 1'b0;

  function automatic logic [127:0] init_line(input logic [15:0] a);
    case (a)
      16'h1230: return 128'h0000_0000_0000_0000_0000_BEEF_0000_0000;
      16'h1330: return 128'h0000_0000_0000_0000_0000_1111_0000_0000;
      16'h1430: return 128'h0000_0000_0000_0000_0000_2222_0000_0000;
      default:  return '0;
    endcase
  endfunction

  // Physical memory: responds LAT cycles after a request appears.
  always @(negedge clk) begin
    bus.pmem_resp = 1'b0;
    if (bus.pmem_read && bus.pmem_write) both_seen = 1'b1;
    if (resp_pulse) begin
      resp_pulse = 1'b0;
    end else if (manual_req != manual_seen) begin
      manual_seen   = manual_req;
      bus.pmem_resp = 1'b1;
      resp_pulse    = 1'b1;
    end else if (pmem_en && (bus.pmem_read || bus.pmem_write)) begin
      wait_cnt++;
      if (wait_cnt == LAT) begin
        wait_cnt = 0;
        if (bus.pmem_write) begin
          wr_cnt++;
          last_wr_addr = bus.pmem_address;
          last_wr_data = bus.pmem_wdata;
          pmem[bus.pmem_address] = bus.pmem_wdata;
        end else begin
          rd_cnt++;
          last_rd_addr   = bus.pmem_address;
          bus.pmem_rdata = pmem.exists(bus.pmem_address) ? pmem[bus.pmem_address]
                                                         : init_line(bus.pmem_address);
        end
        bus.pmem_resp = 1'b1;
        resp_pulse    = 1'b1;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; returns cycles from request to mem_resp (-1 on timeout).
  task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] be,
                        output logic [15:0] rdata, output int cyc);
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = a;
    bus.mem_wdata       = wd;
    bus.mem_byte_enable = be;
    rdata = 'x;
    cyc   = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.mem_resp) begin
        rdata = bus.mem_rdata;
        cyc   = i;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  typedef struct {
    bit           rd;
    bit           wr;
    logic [15:0]  addr;
    logic [15:0]  wd;
    logic [1:0]   be;
    logic [15:0]  exp_rdata;
    int           exp_cyc;
    int           exp_nrd;
    int           exp_nwr;
    logic [15:0]  exp_rd_addr;
    logic [15:0]  exp_wr_addr;
    logic [127:0] exp_wr_data;
  } vec_t;

  localparam logic [127:0] L_55EF = 128'h0000_0000_0000_0000_0000_55EF_0000_0000;
  localparam logic [127:0] L_1530 = 128'h0000_0000_0000_0000_1357_0077_0000_0000;

  initial begin
    vec_t        vq[$];
    logic [15:0] rdata;
    int          cyc;
    int          rd0;
    int          wr0;

    vq.push_back('{1, 0, 16'h1234, 16'h0000, 2'b00, 16'hBEEF, 3, 1, 0, 16'h1230, 16'h0000, '0});
    vq.push_back('{1, 0, 16'h1234, 16'h0000, 2'b00, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000, '0});
    vq.push_back('{0, 1, 16'h1234, 16'h5566, 2'b10, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, '0});
    vq.push_back('{1, 0, 16'h1234, 16'h0000, 2'b00, 16'h55EF, 0, 0, 0, 16'h0000, 16'h0000, '0});
    vq.push_back('{1, 0, 16'h1334, 16'h0000, 2'b00, 16'h1111, 3, 1, 0, 16'h1330, 16'h0000, '0});
    vq.push_back('{1, 0, 16'h1434, 16'h0000, 2'b00, 16'h2222, 6, 1, 1, 16'h1430, 16'h1230, L_55EF});
    vq.push_back('{1, 0, 16'h1334, 16'h0000, 2'b00, 16'h1111, 0, 0, 0, 16'h0000, 16'h0000, '0});
    vq.push_back('{1, 0, 16'h1234, 16'h0000, 2'b00, 16'h55EF, 3, 1, 0, 16'h1230, 16'h0000, '0});
    vq.push_back('{0, 1, 16'h1234, 16'hFFFF, 2'b00, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, '0});
    vq.push_back('{1, 0, 16'h1234, 16'h0000, 2'b00, 16'h55EF, 0, 0, 0, 16'h0000, 16'h0000, '0});
    vq.push_back('{1, 0, 16'h1534, 16'h0000, 2'b00, 16'h0000, 3, 1, 0, 16'h1530, 16'h0000, '0});
    vq.push_back('{1, 0, 16'h1634, 16'h0000, 2'b00, 16'h0000, 6, 1, 1, 16'h1630, 16'h1230, L_55EF});
    vq.push_back('{0, 1, 16'h1536, 16'h1357, 2'b11, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, '0});
    vq.push_back('{0, 1, 16'h1534, 16'hAA77, 2'b01, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, '0});
    vq.push_back('{1, 0, 16'h1534, 16'h0000, 2'b00, 16'h0077, 0, 0, 0, 16'h0000, 16'h0000, '0});
    vq.push_back('{1, 0, 16'h1536, 16'h0000, 2'b00, 16'h1357, 0, 0, 0, 16'h0000, 16'h0000, '0});
    vq.push_back('{1, 1, 16'h1638, 16'h2468, 2'b11, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, '0});
    vq.push_back('{1, 0, 16'h1638, 16'h0000, 2'b00, 16'h2468, 0, 0, 0, 16'h0000, 16'h0000, '0});
    vq.push_back('{1, 0, 16'h1639, 16'h0000, 2'b00, 16'h2468, 0, 0, 0, 16'h0000, 16'h0000, '0});
    vq.push_back('{1, 0, 16'h1734, 16'h0000, 2'b00, 16'h0000, 6, 1, 1, 16'h1730, 16'h1530, L_1530});

    reset               = 1'b1;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 2'b00;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_mem_resp",   bus.mem_resp,     0);
    chk("reset_mem_rdata",  bus.mem_rdata,    0);
    chk("reset_pmem_read",  bus.pmem_read,    0);
    chk("reset_pmem_write", bus.pmem_write,   0);
    chk("reset_pmem_addr",  bus.pmem_address, 0);
    @(negedge clk);

    foreach (vq[i]) begin
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      access(vq[i].rd, vq[i].wr, vq[i].addr, vq[i].wd, vq[i].be, rdata, cyc);
      chk($sformatf("v%0d_cycles", i), 128'(cyc), 128'(vq[i].exp_cyc));
      chk($sformatf("v%0d_pmem_reads", i), 128'(rd_cnt - rd0), 128'(vq[i].exp_nrd));
      chk($sformatf("v%0d_pmem_writes", i), 128'(wr_cnt - wr0), 128'(vq[i].exp_nwr));
      if (vq[i].rd && !vq[i].wr)
        chk($sformatf("v%0d_rdata", i), rdata, vq[i].exp_rdata);
      if (vq[i].exp_nrd != 0)
        chk($sformatf("v%0d_fill_addr", i), last_rd_addr, vq[i].exp_rd_addr);
      if (vq[i].exp_nwr != 0) begin
        chk($sformatf("v%0d_wb_addr", i), last_wr_addr, vq[i].exp_wr_addr);
        chk($sformatf("v%0d_wb_data", i), last_wr_data, vq[i].exp_wr_data);
      end
    end

    // Reset while a fill is outstanding, then a stray pmem_resp in IDLE.
    pmem_en         = 1'b0;
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h2000;
    #1;
    chk("rst_miss_no_resp", bus.mem_resp, 0);
    @(negedge clk);
    chk("rst_alloc_pmem_read", bus.pmem_read, 1);
    chk("rst_alloc_pmem_write", bus.pmem_write, 0);
    chk("rst_alloc_addr", bus.pmem_address, 16'h2000);
    @(negedge clk);
    reset        = 1'b1;
    bus.mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_after_pmem_read", bus.pmem_read, 0);
    chk("rst_after_pmem_write", bus.pmem_write, 0);
    chk("rst_after_mem_resp", bus.mem_resp, 0);
    chk("rst_after_addr", bus.pmem_address, 0);
    manual_req++;
    repeat (2) @(negedge clk);
    #1;
    chk("stray_resp_pmem_read", bus.pmem_read, 0);
    chk("stray_resp_mem_resp", bus.mem_resp, 0);
    @(negedge clk);
    pmem_en = 1'b1;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    access(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, rdata, cyc);
    chk("post_rst_cycles", 128'(cyc), 3);
    chk("post_rst_reads", 128'(rd_cnt - rd0), 1);
    chk("post_rst_writes", 128'(wr_cnt - wr0), 0);
    chk("post_rst_fill_addr", last_rd_addr, 16'h1230);
    chk("post_rst_rdata", rdata, 16'h55EF);

    chk("pmem_rd_wr_exclusive", 128'(both_seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lc3b_cache.md
Name: lc3b_cache

Overview:
Parametrised 2-way set-associative, write-back, write-allocate cache. It sits between the LC-3b CPU core's memory port (mem_* handshake) and physical memory (pmem_* line-wide handshake). It replaces the core's direct memory connection with no change to the core protocol. Hits complete in one cycle. Misses perform an optional dirty-victim writeback, then a line fill.

Parameters:
S_INDEX, 3, log2 of set count (8 sets).
S_OFFSET, 4, log2 of line bytes (16 B line = 128 bits = 8 words).
ADDR_W, 16, address width; tag width = ADDR_W - S_INDEX - S_OFFSET.

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  synchronous, active-high.
mem_read  in  1  CPU read request, held until mem_resp.
mem_write  in  1  CPU write request, held until mem_resp.
mem_byte_enable  in  2  write byte mask (01 low, 10 high, 11 word).
mem_address  in  ADDR_W  CPU byte address; bit 0 ignored for word select.
mem_wdata  in  16  CPU write data.
mem_rdata  out  16  CPU read data, valid while mem_resp=1.
mem_resp  out  1  one-cycle completion pulse.
pmem_read  out  1  line read request, held until pmem_resp.
pmem_write  out  1  line write request, held until pmem_resp.
pmem_address  out  ADDR_W  line-aligned address (low S_OFFSET bits = 0).
pmem_wdata  out  8*2^S_OFFSET  victim line data.
pmem_rdata  in  8*2^S_OFFSET  fill line data, valid with pmem_resp.
pmem_resp  in  1  physical memory completion pulse.

Behaviour:
- Address split: tag = [ADDR_W-1 : S_INDEX+S_OFFSET]; index = [S_INDEX+S_OFFSET-1 : S_OFFSET]; word = [S_OFFSET-1 : 1].
- Per set: 2 × {valid, dirty, tag, line}, plus 1 LRU bit (value = least-recently-used way).
- Reset: all valid, dirty and LRU bits = 0; state = IDLE; mem_resp, pmem_read and pmem_write = 0; pmem_address = 0. Data arrays are not cleared.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: all outputs 0.
- IDLE, request with tag hit in way w (valid and tag match):
  - mem_resp = 1 combinationally, same cycle.
  - Read: mem_rdata = selected word.
  - Write: enabled bytes are merged into the word at the clock edge; dirty[w] = 1.
  - LRU = ~w. Stay in IDLE.
- IDLE, miss: victim = lowest-numbered invalid way, else the LRU way.
  - Victim valid and dirty -> WRITEBACK.
  - Otherwise -> ALLOCATE.
  - mem_resp = 0.
- WRITEBACK:
  - pmem_write = 1; pmem_address = {victim tag, index, 0}; pmem_wdata = victim line.
  - On pmem_resp -> ALLOCATE.
- ALLOCATE:
  - pmem_read = 1; pmem_address = {request tag, index, 0}.
  - On pmem_resp: victim line = pmem_rdata, tag written, valid = 1, dirty = 0 -> IDLE.
  - The request then hits in IDLE on the following cycle.
- Miss latency: 1 (detect) + pmem latency(s) + 1 (hit) cycles to mem_resp.
- pmem_read and pmem_write are never asserted together.
- Victim selection is fixed at miss detection. CPU address, data and mask must stay stable until mem_resp.
- mem_read and mem_write both high is treated as a write.
- mem_byte_enable = 00 on a write: line state, dirty and LRU update exactly as a hit, but no data bytes change.
- Reset mid-WRITEBACK/ALLOCATE: the next cycle is IDLE with pmem_* deasserted. The partial transaction is abandoned; pmem_resp arriving later is ignored.
- pmem_resp in IDLE is ignored.
- Width rule: line word count = 2^(S_OFFSET-1). S_OFFSET ≥ 1 and S_INDEX ≥ 1 are required; tag width ≥ 1.

Test Plan:
- Cold read miss (defaults): read 0x1234 after reset; pmem returns a line with word 2 = 0xBEEF, others 0. Required: pmem_read with pmem_address = 0x1230, no pmem_write; mem_resp one cycle after pmem_resp; mem_rdata = 0xBEEF.
- Read hit: immediately re-read 0x1234 -> mem_resp in the same cycle as the request; 0xBEEF; no pmem activity.
- Byte write: write 0x1234, data 0x5566, mask 10 -> hit. Read back -> 0x55EF.
- Fill second way, then evict dirty line:
  - Read 0x1334 -> fills way 1, no writeback.
  - Read 0x1434 -> LRU way 0 (0x1234, dirty) evicted: pmem_write at 0x1230 with word 2 = 0x55EF, then pmem_read at 0x1430.
  - Read 0x1334 again -> hit.
- LRU update: re-access 0x1334 after the previous case, then read 0x1234 -> victim is the way holding 0x1434, clean, so no pmem_write.
- Reset mid-ALLOCATE: assert reset while pmem_read = 1 -> next cycle pmem_read = 0, mem_resp = 0. Read 0x1234 again -> full miss sequence, since valid bits are cleared.
